fpt_div: RTL
============

FPT_DIV -- requirements
Module: fpt_div

Interface
REQ-001 SHALL have parameter TOTAL_W, default `FPT_TOTAL_WIDTH, total fixed-point word width.
REQ-002 SHALL have parameter INT_W, default `FPT_INT_WIDTH, integer bits including sign; F = TOTAL_W-INT_W fraction bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port ip1, input, TOTAL_W, signed two's-complement dividend.
REQ-008 SHALL have port ip2, input, TOTAL_W, signed two's-complement divisor.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port op, output, TOTAL_W, signed quotient in the same Q format as the operands.
REQ-012 SHALL have port err, output, 1, overflow or divide-by-zero on the current result; qualified by out_valid.

Function
REQ-013 SHALL compute op = (ip1 * 2^F) / ip2, truncated toward zero.
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL assert in_ready only in IDLE; acceptance = in_valid && in_ready at a rising edge.
REQ-016 SHALL, on acceptance with ip2 != 0, capture sign = ip1[MSB]^ip2[MSB] and both magnitudes, and enter CALC.
REQ-017 SHALL, in CALC, perform one restoring shift/subtract step per cycle for N = TOTAL_W+F cycles on the magnitude of ip1 left-shifted by F bits, using an iteration counter.
REQ-018 SHALL enter DONE after the N-th step, applying the sign to the quotient and evaluating overflow; out_valid rises exactly N+1 cycles after the acceptance edge.
REQ-019 SHALL flag overflow when the quotient magnitude exceeds 2^(TOTAL_W-1)-1 for a positive result or 2^(TOTAL_W-1) for a negative result.
REQ-020 SHALL, on acceptance with ip2 == 0, skip CALC and enter DONE on the next edge with err = 1.
REQ-021 SHALL, in DONE, hold op, err and out_valid stable until out_valid && out_ready, then return to IDLE.
REQ-022 SHALL NOT accept new operands in the cycle the result is consumed; in_ready rises the cycle after.
REQ-023 SHALL ignore in_valid and any changes on ip1/ip2 outside IDLE.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-CALC or DONE, return to IDLE: out_valid=0, err=0, op=0, counter=0, in_ready=1 after release.
REQ-025 SHALL discard any in-flight division on reset and produce no result for it.

Configuration
REQ-026 SHALL, with macro FPT_DIV_SAT_EN defined, force op on error to max positive (0111..1) or min negative (1000..0) according to the result sign; divide-by-zero uses the sign of ip1, with 0 treated as positive.
REQ-027 SHALL, without FPT_DIV_SAT_EN, output on overflow the low TOTAL_W bits of the signed quotient, and output op = 0 on divide-by-zero; err behaviour is identical in both builds.

Verification (TOTAL_W=16, INT_W=8, N=24)
REQ-028 SHALL cover the basic case: 0x0300 / 0x0200 (3.0/2.0) -> op=0x0180, err=0, out_valid 25 cycles after acceptance.
REQ-029 SHALL cover sign and truncation: 0xFE80 / 0x0080 -> 0xFD00; 0x0100 / 0x0300 -> 0x0055, err=0.
REQ-030 SHALL cover overflow: 0x6400 / 0x0040 and 0x8000 / 0xFF00 -> err=1, op=0x7FFF with FPT_DIV_SAT_EN; without it, low 16 bits of the quotient.
REQ-031 SHALL cover divide-by-zero: 0xFF00 / 0x0000 -> out_valid 2 cycles after acceptance, err=1, op=0x8000 with FPT_DIV_SAT_EN, op=0x0000 without.
REQ-032 SHALL cover backpressure: out_ready held low 10 cycles in DONE -> op/err stable, in_ready=0; after the handshake, in_ready=1 on the next cycle.
REQ-033 SHALL cover reset mid-operation: rst_n pulsed low at CALC cycle 12 -> out_valid=0 immediately and no result; the next division 0x0300 / 0x0200 completes correctly.

Source files
------------

// File: rtl/fpt_div.sv
// fpt_div: signed fixed-point divider, op = (ip1 * 2^F) / ip2, truncated toward zero.
// Restoring long division on magnitudes, one quotient bit per clock over N = TOTAL_W+F cycles.
//
// Ports
//   clk, rst_n         : clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready  : operand handshake; in_ready is high only while idle
//   ip1, ip2           : signed dividend / divisor, TOTAL_W bits, INT_W integer bits
//   out_valid/out_ready: result handshake; op and err are held until consumed
//   op                 : signed quotient, same Q format as the operands
//   err                : overflow or divide-by-zero, qualified by out_valid
//
// Build option: define FPT_DIV_SAT_EN to saturate op on error (max positive or min
// negative by result sign). Without it, overflow returns the wrapped low bits of the
// quotient and divide-by-zero returns 0.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one shift/subtract per cycle; a zero divisor passes through for one cycle
// DONE  | result registered; out_valid rises one cycle after entry, held until taken

`ifndef FPT_TOTAL_WIDTH
`define FPT_TOTAL_WIDTH 16
`endif
`ifndef FPT_INT_WIDTH
`define FPT_INT_WIDTH 8
`endif

module fpt_div #(
  parameter int TOTAL_W = `FPT_TOTAL_WIDTH,
  parameter int INT_W   = `FPT_INT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] ip1,
  input  logic [TOTAL_W-1:0] ip2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] op,
  output logic               err
);

  localparam int F  = TOTAL_W - INT_W;
  localparam int N  = TOTAL_W + F;
  localparam int CW = $clog2(N + 1);

  localparam logic [N-1:0]       LIM_POS = N'((64'd1 << (TOTAL_W - 1)) - 64'd1);
  localparam logic [N-1:0]       LIM_NEG = N'(64'd1 << (TOTAL_W - 1));
  localparam logic [TOTAL_W-1:0] MAX_POS = {1'b0, {(TOTAL_W-1){1'b1}}};
  localparam logic [TOTAL_W-1:0] MIN_NEG = {1'b1, {(TOTAL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic               sign_q;
  logic               dz_q;
  logic [TOTAL_W-1:0] dvs_q;
  logic [TOTAL_W-1:0] rem_q;
  logic [N-1:0]       quo_q;
  logic [CW-1:0]      cnt_q;
  logic [TOTAL_W-1:0] op_q;
  logic               err_q;
  logic               out_valid_q;

  logic [TOTAL_W-1:0] mag1, mag2;
  logic [TOTAL_W:0]   rem_t, rem_sub;
  logic               ge;
  logic [TOTAL_W-1:0] rem_d;
  logic [N-1:0]       quo_d;
  logic [N-1:0]       quo_signed;
  logic               ovf;
  logic [TOTAL_W-1:0] fin_op;
  logic [TOTAL_W-1:0] dz_op;
  logic               unused_bits;

  always_comb begin
    mag1 = ip1[TOTAL_W-1] ? (~ip1 + TOTAL_W'(1)) : ip1;
    mag2 = ip2[TOTAL_W-1] ? (~ip2 + TOTAL_W'(1)) : ip2;

    // Remainder never reaches the divisor, so TOTAL_W bits plus the shifted-in bit suffice.
    rem_t   = {rem_q, quo_q[N-1]};
    rem_sub = rem_t - {1'b0, dvs_q};
    ge      = (rem_t >= {1'b0, dvs_q});
    rem_d   = ge ? rem_sub[TOTAL_W-1:0] : rem_t[TOTAL_W-1:0];
    // Dividend bits shift out the top while quotient bits fill from the bottom.
    quo_d   = {quo_q[N-2:0], ge};

    // Negative results may reach one step further than positive ones.
    ovf        = (quo_d > (sign_q ? LIM_NEG : LIM_POS));
    quo_signed = sign_q ? (~quo_d + N'(1)) : quo_d;
`ifdef FPT_DIV_SAT_EN
    fin_op = ovf ? (sign_q ? MIN_NEG : MAX_POS) : quo_signed[TOTAL_W-1:0];
    dz_op  = sign_q ? MIN_NEG : MAX_POS;
`else
    fin_op = quo_signed[TOTAL_W-1:0];
    dz_op  = '0;
`endif
  end

  assign unused_bits = ^{rem_sub[TOTAL_W], quo_signed[N-1:TOTAL_W], MIN_NEG, MAX_POS};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      dz_q        <= 1'b0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // A zero divisor keeps only the dividend sign for the saturated result.
            sign_q  <= (ip2 == '0) ? ip1[TOTAL_W-1] : (ip1[TOTAL_W-1] ^ ip2[TOTAL_W-1]);
            dz_q    <= (ip2 == '0);
            dvs_q   <= mag2;
            rem_q   <= '0;
            quo_q   <= N'(mag1) << F;
            cnt_q   <= (ip2 == '0) ? '0 : CW'(N);
            state_q <= CALC;
          end
        end
        CALC: begin
          if (dz_q) begin
            op_q    <= dz_op;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              op_q    <= fin_op;
              err_q   <= ovf;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign err       = err_q;

endmodule
